// File: rtl/reset_release_sequencer.sv
// -----------------------------------------------------------------------------
// reset_release_sequencer
//
// Turns the device init-done indication into a set of staggered channel resets.
// The active-low, asynchronous ninit_done is synchronised into clk. After
// configuration completes, every channel is held in reset for HOLD_CYCLES. The
// channels are then released one by one in index order, STAGGER_CYCLES apart.
// In RUN, each channel can be pulsed back into reset by its soft-reset request.
// Losing init-done in any state re-asserts every channel reset.
//
// Ports:
//   clk           single clock for all logic
//   rst           synchronous, active-high reset
//   ninit_done    active-low device init-done, asynchronous to clk
//   chan_rst_req  per-channel soft-reset request, level-sampled every cycle
//   chan_rst      active-high channel resets (registered)
//   all_released  high in RUN while no channel reset is asserted (registered)
//   seq_state     FSM state: 0 WAIT_INIT, 1 HOLD, 2 RELEASE, 3 RUN
// -----------------------------------------------------------------------------
module reset_release_sequencer #(
    parameter int NUM_CHAN       = 2,
    parameter int SYNC_STAGES    = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ninit_done,
    input  logic [NUM_CHAN-1:0] chan_rst_req,
    output logic [NUM_CHAN-1:0] chan_rst,
    output logic                all_released,
    output logic [1:0]          seq_state
);

    localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int IW      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_CHAN - 1);

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // ninit_done synchroniser. The flops reset to 1 ("not done"), so a reset
    // never produces a spurious init_ok.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   init_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ninit_done};
        end
    end

    assign init_ok = ~sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    state_t              state_reg, state_next;
    logic [CW-1:0]       seq_cnt_reg, seq_cnt_next;
    logic [IW-1:0]       rel_idx_reg, rel_idx_next;   // next channel to release
    logic [NUM_CHAN-1:0] release_mask;                // channels released this edge
    logic [NUM_CHAN-1:0] chan_rst_reg, chan_rst_next;
    logic                all_released_reg, all_released_next;
    logic                soft_en;

    always_comb begin
        state_next   = state_reg;
        seq_cnt_next = seq_cnt_reg;
        rel_idx_next = rel_idx_reg;
        release_mask = '0;

        case (state_reg)
            WAIT_INIT: begin
                seq_cnt_next = '0;
                rel_idx_next = '0;
                if (init_ok) begin
                    state_next = HOLD;
                end
            end

            HOLD: begin
                if (seq_cnt_reg == HOLD_LAST) begin
                    // Channel 0 always leaves reset together with the HOLD exit.
                    seq_cnt_next    = '0;
                    release_mask[0] = 1'b1;
                    if (NUM_CHAN == 1) begin
                        state_next = RUN;
                    end else begin
                        state_next   = RELEASE;
                        rel_idx_next = IW'(1);
                    end
                end else begin
                    seq_cnt_next = seq_cnt_reg + CW'(1);
                end
            end

            RELEASE: begin
                if (seq_cnt_reg == STAG_LAST) begin
                    seq_cnt_next = '0;
                    for (int i = 0; i < NUM_CHAN; i++) begin
                        if (rel_idx_reg == IW'(i)) begin
                            release_mask[i] = 1'b1;
                        end
                    end
                    if (rel_idx_reg == LAST_IDX) begin
                        state_next = RUN;
                    end else begin
                        rel_idx_next = rel_idx_reg + IW'(1);
                    end
                end else begin
                    seq_cnt_next = seq_cnt_reg + CW'(1);
                end
            end

            RUN: begin
                seq_cnt_next = '0;
            end

            default: begin
                state_next = WAIT_INIT;
            end
        endcase

        // Loss of init-done overrides every other transition.
        if ((state_reg != WAIT_INIT) && !init_ok) begin
            state_next   = WAIT_INIT;
            seq_cnt_next = '0;
            rel_idx_next = '0;
            release_mask = '0;
        end
    end

    // Soft resets are only serviced while staying in RUN; a request on the edge
    // that enters RUN is still in RELEASE/HOLD and is ignored.
    assign soft_en = (state_reg == RUN) && (state_next == RUN);

    // -------------------------------------------------------------------------
    // Per-channel reset bit and soft-reset pulse counter
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_chan
            logic [CW-1:0] soft_cnt_reg, soft_cnt_next;
            logic          rst_bit_next;

            always_comb begin
                soft_cnt_next = soft_cnt_reg;
                rst_bit_next  = chan_rst_reg[gi];
                if (state_next == WAIT_INIT) begin
                    rst_bit_next  = 1'b1;
                    soft_cnt_next = '0;
                end else if (soft_en) begin
                    if (chan_rst_req[gi]) begin
                        // A new request (re)starts a full-length pulse.
                        rst_bit_next  = 1'b1;
                        soft_cnt_next = HOLD_LOAD;
                    end else if (soft_cnt_reg != '0) begin
                        soft_cnt_next = soft_cnt_reg - CW'(1);
                        if (soft_cnt_reg == CW'(1)) begin
                            rst_bit_next = 1'b0;
                        end
                    end
                end else if (release_mask[gi]) begin
                    rst_bit_next = 1'b0;
                end
            end

            assign chan_rst_next[gi] = rst_bit_next;

            always_ff @(posedge clk) begin
                if (rst) begin
                    soft_cnt_reg <= '0;
                end else begin
                    soft_cnt_reg <= soft_cnt_next;
                end
            end
        end
    endgenerate

    assign all_released_next = (state_next == RUN) && (chan_rst_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= WAIT_INIT;
            seq_cnt_reg      <= '0;
            rel_idx_reg      <= '0;
            chan_rst_reg     <= '1;
            all_released_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            seq_cnt_reg      <= seq_cnt_next;
            rel_idx_reg      <= rel_idx_next;
            chan_rst_reg     <= chan_rst_next;
            all_released_reg <= all_released_next;
        end
    end

    assign chan_rst     = chan_rst_reg;
    assign all_released = all_released_reg;
    assign seq_state    = state_reg;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for reset_release_sequencer. A default two-channel instance covers
// power-up, held-in-init, soft reset, retrigger and init loss; a single-channel
// instance covers a mid-HOLD reset and the direct HOLD -> RUN exit.
// -----------------------------------------------------------------------------
module tb_reset_release_sequencer;

    typedef struct {
        int         off;   // edges after E (E = first edge sampling ninit_done low)
        logic [1:0] cr;
        logic       ar;
        logic [1:0] st;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       ninit_done;
    logic [1:0] chan_rst_req;
    logic [1:0] chan_rst;
    logic       all_released;
    logic [1:0] seq_state;

    logic       rst1;
    logic       ninit_done1;
    logic [0:0] chan_rst_req1;
    logic [0:0] chan_rst1;
    logic       all_released1;
    logic [1:0] seq_state1;

    int n_cmp;
    int n_bad;

    vec_t pu_tab[9];

    reset_release_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .ninit_done   (ninit_done),
        .chan_rst_req (chan_rst_req),
        .chan_rst     (chan_rst),
        .all_released (all_released),
        .seq_state    (seq_state)
    );

    reset_release_sequencer #(.NUM_CHAN(1)) dut1 (
        .clk          (clk),
        .rst          (rst1),
        .ninit_done   (ninit_done1),
        .chan_rst_req (chan_rst_req1),
        .chan_rst     (chan_rst1),
        .all_released (all_released1),
        .seq_state    (seq_state1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string name, input logic [1:0] cr, input logic ar,
                            input logic [1:0] st);
        n_cmp++;
        if ({chan_rst, all_released, seq_state} !== {cr, ar, st}) begin
            n_bad++;
            $display("FAIL %s: got chan_rst=%b all_released=%b seq_state=%0d, expected chan_rst=%b all_released=%b seq_state=%0d",
                     name, chan_rst, all_released, seq_state, cr, ar, st);
        end else begin
            $display("ok   %s: chan_rst=%b all_released=%b seq_state=%0d",
                     name, chan_rst, all_released, seq_state);
        end
    endtask

    task automatic chk_one(input string name, input logic cr, input logic ar,
                           input logic [1:0] st);
        n_cmp++;
        if ({chan_rst1, all_released1, seq_state1} !== {cr, ar, st}) begin
            n_bad++;
            $display("FAIL %s: got chan_rst=%b all_released=%b seq_state=%0d, expected chan_rst=%b all_released=%b seq_state=%0d",
                     name, chan_rst1, all_released1, seq_state1, cr, ar, st);
        end else begin
            $display("ok   %s: chan_rst=%b all_released=%b seq_state=%0d",
                     name, chan_rst1, all_released1, seq_state1);
        end
    endtask

    // Called just before edge E (ninit_done already driven low); walks the
    // power-up table up to offset 'upto' and leaves the time at E+last_offset.
    task automatic run_table(input string tag, input int upto);
        int k = -1;
        for (int i = 0; i < 9; i++) begin
            if (pu_tab[i].off <= upto) begin
                while (k < pu_tab[i].off) begin
                    tick();
                    k++;
                end
                chk_main($sformatf("%s_E+%0d", tag, pu_tab[i].off),
                         pu_tab[i].cr, pu_tab[i].ar, pu_tab[i].st);
            end
        end
    endtask

    initial begin
        // Defaults: chan_rst[0] falls at E+3+16, chan_rst[1] at E+3+16+8.
        pu_tab[0] = '{0,  2'b11, 1'b0, 2'd0};
        pu_tab[1] = '{2,  2'b11, 1'b0, 2'd0};
        pu_tab[2] = '{3,  2'b11, 1'b0, 2'd1};
        pu_tab[3] = '{18, 2'b11, 1'b0, 2'd1};
        pu_tab[4] = '{19, 2'b10, 1'b0, 2'd2};
        pu_tab[5] = '{20, 2'b10, 1'b0, 2'd2};
        pu_tab[6] = '{26, 2'b10, 1'b0, 2'd2};
        pu_tab[7] = '{27, 2'b00, 1'b1, 2'd3};
        pu_tab[8] = '{30, 2'b00, 1'b1, 2'd3};

        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        ninit_done    = 1'b1;
        chan_rst_req  = 2'b00;
        rst1          = 1'b1;
        ninit_done1   = 1'b1;
        chan_rst_req1 = 1'b0;

        // Reset state.
        repeat (4) tick();
        chk_main("reset_values", 2'b11, 1'b0, 2'd0);
        chk_one("reset_values_n1", 1'b1, 1'b0, 2'd0);

        // Held in init: nothing may move while ninit_done stays high.
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            chk_main($sformatf("held_init_%0d", i), 2'b11, 1'b0, 2'd0);
        end

        // Power-up sequence.
        ninit_done = 1'b0;
        run_table("powerup", 30);

        // Soft reset on channel 1: high T..T+15, low at T+16.
        chan_rst_req = 2'b10;
        tick();
        chan_rst_req = 2'b00;
        chk_main("soft1_T+0", 2'b10, 1'b0, 2'd3);
        for (int j = 1; j < 16; j++) begin
            tick();
            if (j == 8 || j == 15) chk_main($sformatf("soft1_T+%0d", j), 2'b10, 1'b0, 2'd3);
        end
        tick();
        chk_main("soft1_T+16", 2'b00, 1'b1, 2'd3);

        // Retrigger on channel 0 at T and T+10: clears at T+26.
        chan_rst_req = 2'b01;
        tick();
        chan_rst_req = 2'b00;
        chk_main("retrig_T+0", 2'b01, 1'b0, 2'd3);
        repeat (9) tick();
        chan_rst_req = 2'b01;
        tick();
        chan_rst_req = 2'b00;
        chk_main("retrig_T+10", 2'b01, 1'b0, 2'd3);
        repeat (15) tick();
        chk_main("retrig_T+25", 2'b01, 1'b0, 2'd3);
        tick();
        chk_main("retrig_T+26", 2'b00, 1'b1, 2'd3);

        // Simultaneous requests on both channels.
        chan_rst_req = 2'b11;
        tick();
        chan_rst_req = 2'b00;
        chk_main("both_T+0", 2'b11, 1'b0, 2'd3);
        repeat (15) tick();
        chk_main("both_T+15", 2'b11, 1'b0, 2'd3);
        tick();
        chk_main("both_T+16", 2'b00, 1'b1, 2'd3);

        // Init lost in RUN: everything back in reset at F+3.
        ninit_done = 1'b1;
        repeat (3) tick();
        chk_main("lost_run_F+2", 2'b00, 1'b1, 2'd3);
        tick();
        chk_main("lost_run_F+3", 2'b11, 1'b0, 2'd0);

        // Init lost during RELEASE (sampled high at E+22).
        ninit_done = 1'b0;
        run_table("relost", 20);
        tick();
        ninit_done = 1'b1;
        tick();
        chk_main("relost_E+22", 2'b10, 1'b0, 2'd2);
        repeat (2) tick();
        chk_main("relost_E+24", 2'b10, 1'b0, 2'd2);
        tick();
        chk_main("relost_E+25", 2'b11, 1'b0, 2'd0);

        // Full restart after init returns.
        ninit_done = 1'b0;
        run_table("restart", 30);

        // Single-channel instance: reset in HOLD, then HOLD -> RUN directly.
        rst1        = 1'b0;
        ninit_done1 = 1'b0;
        repeat (11) tick();
        chk_one("n1_hold_E+10", 1'b1, 1'b0, 2'd1);
        rst1 = 1'b1;
        tick();
        chk_one("n1_midreset", 1'b1, 1'b0, 2'd0);
        rst1 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 2)  chk_one("n1_E+2", 1'b1, 1'b0, 2'd0);
            if (k == 3)  chk_one("n1_E+3", 1'b1, 1'b0, 2'd1);
            if (k == 18) chk_one("n1_E+18", 1'b1, 1'b0, 2'd1);
            if (k == 19) chk_one("n1_E+19", 1'b0, 1'b1, 2'd3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
